// File: rtl/arp_rx_parser.sv
// arp_rx_parser: MII (nibble) receive-side ARP reply filter.
// Assembles bytes high nibble first, checks the Ethernet/ARP header against
// the station addresses, and reports each frame with one arp_valid or
// arp_drop pulse. On accept it latches the sender MAC/IP.
// Build option: define ARP_RX_CRC_CHECK_EN to add CRC-32 FCS checking;
// without it the FCS bytes are only counted.
module arp_rx_parser #(
    parameter logic [47:0] LOCAL_MAC = 48'hAC162D0B5AA2,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A80090
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [3:0]  rx_data,
    output logic        arp_valid,
    output logic        arp_drop,
    output logic [47:0] sender_mac,
    output logic [31:0] sender_ip
);

    typedef enum logic [1:0] {IDLE, PRE, BODY, WAIT_END} state_t;

    state_t      state_r;
    logic        armed_r;      // rx_dv seen low since reset release
    logic        prev_a_r;     // previous preamble nibble was 0xA
    logic        phase_r;      // 0: expecting high nibble, 1: low nibble
    logic [3:0]  hi_nib_r;
    logic [6:0]  byte_idx_r;
    logic        dst_local_r;  // destination matches LOCAL_MAC so far
    logic        dst_bcast_r;  // destination is all-ones so far
    logic [47:0] cand_mac_r;
    logic [31:0] cand_ip_r;
    logic        res_pend_r;
    logic        res_ok_r;

    logic [7:0]  cur_byte_s;
    logic [7:0]  mac_byte_s;
    logic [7:0]  ip_byte_s;
    logic [1:0]  ip_sel_s;
    logic        dst_local_next_s;
    logic        dst_bcast_next_s;
    logic        byte_ok_s;
    logic        crc_ok_s;
    logic        end_ok_s;

`ifdef ARP_RX_CRC_CHECK_EN
    logic [31:0] crc_r;
    logic [31:0] crc_next_s;

    // CRC-32, MSB-aligned register, data bits fed LSB first (Ethernet order)
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h00000000);
        end
        return c;
    endfunction
`endif

    // Byte assembly, per-byte header comparison and end-of-frame verdict
    always_comb begin
        cur_byte_s = {hi_nib_r, rx_data};
        case (byte_idx_r[2:0])
            3'd0:    mac_byte_s = LOCAL_MAC[47:40];
            3'd1:    mac_byte_s = LOCAL_MAC[39:32];
            3'd2:    mac_byte_s = LOCAL_MAC[31:24];
            3'd3:    mac_byte_s = LOCAL_MAC[23:16];
            3'd4:    mac_byte_s = LOCAL_MAC[15:8];
            3'd5:    mac_byte_s = LOCAL_MAC[7:0];
            default: mac_byte_s = 8'h00;
        endcase
        // byte 38 is the first TPA byte; 38 mod 4 = 2
        ip_sel_s = byte_idx_r[1:0] - 2'd2;
        case (ip_sel_s)
            2'd0:    ip_byte_s = LOCAL_IP[31:24];
            2'd1:    ip_byte_s = LOCAL_IP[23:16];
            2'd2:    ip_byte_s = LOCAL_IP[15:8];
            2'd3:    ip_byte_s = LOCAL_IP[7:0];
            default: ip_byte_s = 8'h00;
        endcase
        dst_local_next_s = dst_local_r & (cur_byte_s == mac_byte_s);
        dst_bcast_next_s = dst_bcast_r & (cur_byte_s == 8'hFF);
        case (byte_idx_r)
            7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5:
                     byte_ok_s = dst_local_next_s | dst_bcast_next_s;
            7'd12:   byte_ok_s = (cur_byte_s == 8'h08);
            7'd13:   byte_ok_s = (cur_byte_s == 8'h06);
            7'd14:   byte_ok_s = (cur_byte_s == 8'h00);
            7'd15:   byte_ok_s = (cur_byte_s == 8'h01);
            7'd16:   byte_ok_s = (cur_byte_s == 8'h08);
            7'd17:   byte_ok_s = (cur_byte_s == 8'h00);
            7'd18:   byte_ok_s = (cur_byte_s == 8'h06);
            7'd19:   byte_ok_s = (cur_byte_s == 8'h04);
            7'd20:   byte_ok_s = (cur_byte_s == 8'h00);
            7'd21:   byte_ok_s = (cur_byte_s == 8'h02);
            7'd38, 7'd39, 7'd40, 7'd41:
                     byte_ok_s = (cur_byte_s == ip_byte_s);
            default: byte_ok_s = 1'b1;
        endcase
`ifdef ARP_RX_CRC_CHECK_EN
        crc_next_s = crc_byte(crc_r, cur_byte_s);
        crc_ok_s   = (crc_r == 32'hC704DD7B);
`else
        crc_ok_s   = 1'b1;
`endif
        end_ok_s = (phase_r == 1'b0) && (byte_idx_r >= 7'd64) && crc_ok_s;
    end

    // Receive FSM, capture registers and registered result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            armed_r     <= 1'b0;
            prev_a_r    <= 1'b0;
            phase_r     <= 1'b0;
            hi_nib_r    <= 4'h0;
            byte_idx_r  <= 7'd0;
            dst_local_r <= 1'b0;
            dst_bcast_r <= 1'b0;
            cand_mac_r  <= 48'h0;
            cand_ip_r   <= 32'h0;
            res_pend_r  <= 1'b0;
            res_ok_r    <= 1'b0;
            arp_valid   <= 1'b0;
            arp_drop    <= 1'b0;
            sender_mac  <= 48'h0;
            sender_ip   <= 32'h0;
`ifdef ARP_RX_CRC_CHECK_EN
            crc_r       <= 32'hFFFFFFFF;
`endif
        end else begin
            arp_valid  <= 1'b0;
            arp_drop   <= 1'b0;
            res_pend_r <= 1'b0;
            if (!rx_dv) begin
                armed_r <= 1'b1;
            end
            if (res_pend_r) begin
                if (res_ok_r) begin
                    arp_valid  <= 1'b1;
                    sender_mac <= cand_mac_r;
                    sender_ip  <= cand_ip_r;
                end else begin
                    arp_drop <= 1'b1;
                end
            end
            case (state_r)
                IDLE: begin
                    if (rx_dv && armed_r) begin
                        state_r  <= PRE;
                        prev_a_r <= (rx_data == 4'hA);
                    end
                end
                PRE: begin
                    if (!rx_dv) begin
                        state_r    <= IDLE;
                        res_pend_r <= 1'b1;
                        res_ok_r   <= 1'b0;
                    end else if (rx_er) begin
                        state_r <= WAIT_END;
                    end else if (rx_data == 4'hA) begin
                        prev_a_r <= 1'b1;
                    end else if ((rx_data == 4'hB) && prev_a_r) begin
                        state_r     <= BODY;
                        phase_r     <= 1'b0;
                        byte_idx_r  <= 7'd0;
                        dst_local_r <= 1'b1;
                        dst_bcast_r <= 1'b1;
`ifdef ARP_RX_CRC_CHECK_EN
                        crc_r       <= 32'hFFFFFFFF;
`endif
                    end else begin
                        state_r <= WAIT_END;
                    end
                end
                BODY: begin
                    if (!rx_dv) begin
                        state_r    <= IDLE;
                        res_pend_r <= 1'b1;
                        res_ok_r   <= end_ok_s;
                    end else if (rx_er) begin
                        state_r <= WAIT_END;
                    end else if (!phase_r) begin
                        hi_nib_r <= rx_data;
                        phase_r  <= 1'b1;
                    end else begin
                        phase_r     <= 1'b0;
                        dst_local_r <= dst_local_next_s;
                        dst_bcast_r <= dst_bcast_next_s;
                        if (byte_idx_r != 7'd127) begin
                            byte_idx_r <= byte_idx_r + 7'd1;
                        end
`ifdef ARP_RX_CRC_CHECK_EN
                        crc_r <= crc_next_s;
`endif
                        if ((byte_idx_r >= 7'd22) && (byte_idx_r <= 7'd27)) begin
                            cand_mac_r <= {cand_mac_r[39:0], cur_byte_s};
                        end
                        if ((byte_idx_r >= 7'd28) && (byte_idx_r <= 7'd31)) begin
                            cand_ip_r <= {cand_ip_r[23:0], cur_byte_s};
                        end
                        if (!byte_ok_s) begin
                            state_r <= WAIT_END;
                        end
                    end
                end
                WAIT_END: begin
                    if (!rx_dv) begin
                        state_r    <= IDLE;
                        res_pend_r <= 1'b1;
                        res_ok_r   <= 1'b0;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
